// File: rtl/if_prefetch_queue_pkg.sv
// ifq_pkg: fetch-queue state encoding, entry layout {inst, pc4} and word increment
package ifq_pkg;
  typedef enum logic [1:0] {IFQ_IDLE = 2'd0, IFQ_REQ = 2'd1, IFQ_DROP = 2'd2} ifq_state_t;
  localparam int IFQ_ENTRY_W = 64;
  localparam logic [31:0] IFQ_WORD_INC = 32'd4;
endpackage

// File: rtl/if_prefetch_queue_if.sv
// if_prefetch_queue_if: redirect, imem req/ack (mem_req/addr/ack/rdata) and IF/ID valid/ready (id_ready/valid/inst/pc4); master=queue, slave=environment
interface if_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  modport master(input redirect, redirect_pc, mem_ack, mem_rdata, id_ready, output mem_req, mem_addr, id_valid, id_inst, id_pc4);
  modport slave(output redirect, redirect_pc, mem_ack, mem_rdata, id_ready, input mem_req, mem_addr, id_valid, id_inst, id_pc4);
endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// ifq_fifo: DEPTH x 64 entry queue (clk, rst, flush, push/wdata, pop, rdata=head, count) with same-cycle push+pop
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [IFQ_ENTRY_W-1:0] wdata,
  output logic [IFQ_ENTRY_W-1:0] rdata,
  output logic [CW-1:0]          count
);
  logic [IFQ_ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: imem prefetch FSM + queue feeding IF/ID (CLK, CLR, bus: if_prefetch_queue_if.master; IFQ_STATS_EN adds stall_cnt/flush_cnt)
module if_prefetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic CLK,
  input logic CLR,
  if_prefetch_queue_if.master bus
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  ifq_state_t state;
  logic [31:0] pc_next, addr_inc;
  logic [CW-1:0] count, post_count;
  logic push, pop;
  logic [IFQ_ENTRY_W-1:0] head;
  assign addr_inc     = bus.mem_addr + IFQ_WORD_INC;
  assign push         = state == IFQ_REQ && bus.mem_ack && !bus.redirect;
  assign pop          = bus.id_valid && bus.id_ready && !bus.redirect;
  assign post_count   = count + CW'(push) - CW'(pop);
  assign bus.id_valid = count != '0;
  assign bus.id_inst  = bus.id_valid ? head[63:32] : '0;
  assign bus.id_pc4   = bus.id_valid ? head[31:0] : '0;
  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (CLK),
    .rst  (CLR),
    .flush(bus.redirect),
    .push (push),
    .pop  (pop),
    .wdata({bus.mem_rdata, addr_inc}),
    .rdata(head),
    .count(count)
  );
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state        <= IFQ_IDLE;
      pc_next      <= RESET_PC;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= RESET_PC;
    end else if (bus.redirect) begin
      pc_next     <= bus.redirect_pc & ~32'd3;
      state       <= (state == IFQ_IDLE || bus.mem_ack) ? IFQ_IDLE : IFQ_DROP;
      bus.mem_req <= state != IFQ_IDLE && !bus.mem_ack;
    end else begin
      case (state)
        IFQ_IDLE:
          if (count < CW'(DEPTH)) begin
            state        <= IFQ_REQ;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= pc_next;
          end
        IFQ_REQ:
          if (bus.mem_ack) begin
            pc_next <= addr_inc;
            if (post_count < CW'(DEPTH)) bus.mem_addr <= addr_inc;
            else begin
              state       <= IFQ_IDLE;
              bus.mem_req <= 1'b0;
            end
          end
        default:
          if (bus.mem_ack) begin
            state       <= IFQ_IDLE;
            bus.mem_req <= 1'b0;
          end
      endcase
    end
  end
`ifdef IFQ_STATS_EN
  always_ff @(posedge CLK) begin
    if (CLR) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.id_valid && !bus.id_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      if (bus.redirect && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif
endmodule
